// File: rtl/fpga_cfg_pkg.sv
// fpga_cfg_pkg: shared fixed-point config, width helpers and sequencer types
package fpga_cfg_pkg;
  localparam int FP_WIDTH = 32;
  localparam int FP_QFRAC = 16;
  localparam int GBM_N_PATHS = 1024;
  localparam int GBM_N_STEPS = 50;
  function automatic int path_w(input int n_paths);
    return (n_paths > 1) ? $clog2(n_paths) : 1;
  endfunction
  function automatic int step_w(input int n_steps);
    return $clog2(n_steps + 1);
  endfunction
  typedef struct packed {
    logic [path_w(GBM_N_PATHS)-1:0] path;
    logic [step_w(GBM_N_STEPS)-1:0] step;
  } gbm_tag_t;
  typedef enum logic [1:0] {SEQ_IDLE, SEQ_RUN, SEQ_DRAIN} seq_state_t;
endpackage

// File: rtl/gbm_tag_fifo.sv
// gbm_tag_fifo: in-order tag FIFO mirroring the GBM lane contents
module gbm_tag_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
  assign dout = mem[rd_ptr[AW-1:0]];
  // storage write, no reset needed since pointers gate visibility
  always_ff @(posedge clk)
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  // pointer update; extra MSB distinguishes full from empty
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push && !full);
      rd_ptr <= rd_ptr + PW'(pop && !empty);
    end
endmodule

// File: rtl/gbm_path_sequencer.sv
// gbm_path_sequencer: launches and recirculates Monte-Carlo paths through one GBM lane
module gbm_path_sequencer import fpga_cfg_pkg::*; #(
  parameter int WIDTH = FP_WIDTH,
  parameter int QFRAC = FP_QFRAC,
  parameter int N_PATHS = 1024,
  parameter int N_STEPS = 50,
  parameter int MAX_INFLIGHT = 16,
  localparam int PATH_W = path_w(N_PATHS),
  localparam int STEP_W = step_w(N_STEPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  S0,
  input  logic [WIDTH-1:0]  r,
  input  logic [WIDTH-1:0]  sigma,
  input  logic [WIDTH-1:0]  dt,
  input  logic              z_valid,
  output logic              z_ready,
  input  logic [WIDTH-1:0]  z,
  output logic              gbm_valid,
  input  logic              gbm_ready,
  output logic [WIDTH-1:0]  gbm_z,
  output logic [WIDTH-1:0]  gbm_S,
  output logic [WIDTH-1:0]  gbm_r,
  output logic [WIDTH-1:0]  gbm_sigma,
  output logic [WIDTH-1:0]  gbm_dt,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [WIDTH-1:0]  res_S,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_S,
  output logic [PATH_W-1:0] out_path,
  output logic [STEP_W-1:0] out_step,
  output logic              busy,
  output logic              done
);
  localparam int CNT_W = PATH_W + 1;
  localparam int IF_W = $clog2(MAX_INFLIGHT) + 1;
  localparam int TAG_W = PATH_W + STEP_W;
  if (QFRAC >= WIDTH) begin : g_bad_qfrac
    $error("gbm_path_sequencer: QFRAC must be below WIDTH");
  end
  seq_state_t state, state_n;
  logic [CNT_W-1:0] new_path, finished;
  logic [IF_W-1:0] inflight;
  logic [WIDTH-1:0] s0_q, recirc_s;
  logic [PATH_W-1:0] recirc_path, head_path;
  logic [STEP_W-1:0] recirc_step, head_step, next_step;
  logic [TAG_W-1:0] issue_tag, head_tag;
  logic recirc_valid, locked, lock_recirc, sel_recirc, new_avail;
  logic gbm_fire, recirc_fire, new_fire, res_fire, last, start_ok, tag_empty, tag_full;
  assign start_ok = state == SEQ_IDLE && start;
  assign busy = state != SEQ_IDLE;
  assign new_avail = state == SEQ_RUN && inflight < IF_W'(MAX_INFLIGHT);
  assign sel_recirc = locked ? lock_recirc : recirc_valid;
  assign gbm_valid = z_valid && (sel_recirc ? recirc_valid : new_avail);
  assign gbm_fire = gbm_valid && gbm_ready;
  assign z_ready = gbm_fire;
  assign recirc_fire = gbm_fire && sel_recirc;
  assign new_fire = gbm_fire && !sel_recirc;
  assign gbm_S = sel_recirc ? recirc_s : s0_q;
  assign gbm_z = z;
  assign issue_tag = sel_recirc ? {recirc_path, recirc_step} : {new_path[PATH_W-1:0], STEP_W'(0)};
  assign {head_path, head_step} = head_tag;
  assign next_step = head_step + 1'b1;
  assign last = next_step == STEP_W'(N_STEPS);
  assign res_ready = !tag_empty && (!out_valid || out_ready) && (last || !recirc_valid || recirc_fire);
  assign res_fire = res_valid && res_ready;
  assign done = busy && finished == CNT_W'(N_PATHS) && out_valid && out_ready;
  gbm_tag_fifo #(.W(TAG_W), .DEPTH(MAX_INFLIGHT)) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (gbm_fire),
    .din   (issue_tag),
    .pop   (res_fire),
    .dout  (head_tag),
    .empty (tag_empty),
    .full  (tag_full)
  );
  // run FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= SEQ_IDLE;
    else state <= state_n;
  // drain begins as the last path launches; idle once its final sample leaves
  always_comb begin
    state_n = done ? SEQ_IDLE :
              start_ok ? SEQ_RUN :
              (new_fire && new_path == CNT_W'(N_PATHS - 1)) ? SEQ_DRAIN : state;
  end
  // run parameters and path counters, cleared on an accepted start
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s0_q <= '0;
      gbm_r <= '0;
      gbm_sigma <= '0;
      gbm_dt <= '0;
      new_path <= '0;
      finished <= '0;
      inflight <= '0;
    end else if (start_ok) begin
      s0_q <= S0;
      gbm_r <= r;
      gbm_sigma <= sigma;
      gbm_dt <= dt;
      new_path <= '0;
      finished <= '0;
      inflight <= '0;
    end else begin
      new_path <= new_path + CNT_W'(new_fire);
      finished <= finished + CNT_W'(res_fire && last);
      inflight <= inflight + IF_W'(new_fire) - IF_W'(res_fire && last);
    end
  // hold source choice while an offered issue is stalled so the payload stays put
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      locked <= 1'b0;
      lock_recirc <= 1'b0;
    end else begin
      locked <= gbm_valid && !gbm_ready;
      lock_recirc <= sel_recirc;
    end
  // single-entry recirculation register for non-final step results
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      recirc_valid <= 1'b0;
      recirc_s <= '0;
      recirc_path <= '0;
      recirc_step <= '0;
    end else if (res_fire && !last) begin
      recirc_valid <= 1'b1;
      recirc_s <= res_S;
      recirc_path <= head_path;
      recirc_step <= next_step;
    end else if (recirc_fire) recirc_valid <= 1'b0;
  // output register toward the path buffer
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_S <= '0;
      out_path <= '0;
      out_step <= '0;
    end else if (res_fire) begin
      out_valid <= 1'b1;
      out_S <= res_S;
      out_path <= head_path;
      out_step <= next_step;
    end else if (out_ready) out_valid <= 1'b0;
  // the lane is in order, so a result without a pending tag is a protocol error
  a_res_tag: assert property (@(posedge clk) disable iff (!rst_n) !(res_valid && tag_empty));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(gbm_fire && tag_full));
endmodule

// File: tb/tb_gbm_path_sequencer.sv
// tb_gbm_path_sequencer: directed bench with a 6-cycle S+ONE GBM lane model
module tb_gbm_path_sequencer;
  localparam int NP = 16;
  localparam int NS = 3;
  localparam logic [31:0] ONE = 32'h0001_0000;
  localparam logic [31:0] S100 = 32'd100 << 16;
  localparam logic [31:0] S200 = 32'd200 << 16;
  typedef struct {logic [31:0] s; int due;} pipe_t;
  logic clk = 0, rst_n = 0, start = 0;
  logic [31:0] S0 = 0, r = 0, sigma = 0, dt = 0, z = 0;
  logic z_valid = 0, gbm_ready = 1, res_valid = 0, out_ready = 1;
  logic [31:0] res_S = 0;
  logic z_ready, gbm_valid, res_ready, out_valid, busy, done;
  logic [31:0] gbm_z, gbm_S, gbm_r, gbm_sigma, gbm_dt, out_S;
  logic [3:0] out_path;
  logic [1:0] out_step;
  int n_checks = 0, n_fail = 0, cyc = 0;
  int n_samples, val_err, order_err, stab_err, gstab_err, done_cnt, launches, lasts, max_if;
  int last_step [NP];
  logic [31:0] gbm_log [$];
  pipe_t pipe [$];
  bit first_seen, ostall, gstall, gbm_fire_s, res_fire_s, out_rand = 0;
  int first_path, first_step;
  logic [31:0] first_s, gpl, gbm_s_s, s0_ref = S100;
  logic [37:0] opl;
  gbm_path_sequencer #(.WIDTH(32), .QFRAC(16), .N_PATHS(NP), .N_STEPS(NS), .MAX_INFLIGHT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .S0(S0), .r(r), .sigma(sigma), .dt(dt),
    .z_valid(z_valid), .z_ready(z_ready), .z(z),
    .gbm_valid(gbm_valid), .gbm_ready(gbm_ready), .gbm_z(gbm_z), .gbm_S(gbm_S),
    .gbm_r(gbm_r), .gbm_sigma(gbm_sigma), .gbm_dt(gbm_dt),
    .res_valid(res_valid), .res_ready(res_ready), .res_S(res_S),
    .out_valid(out_valid), .out_ready(out_ready), .out_S(out_S), .out_path(out_path),
    .out_step(out_step), .busy(busy), .done(done));
  always #5 clk = ~clk;
  // monitor: samples handshakes mid-cycle, when the next edge's inputs are settled
  always @(negedge clk) begin
    gbm_fire_s = rst_n && gbm_valid && gbm_ready;
    res_fire_s = rst_n && res_valid && res_ready;
    gbm_s_s = gbm_S;
    if (rst_n) begin
      if (gbm_fire_s) begin
        gbm_log.push_back(gbm_S);
        if (gbm_S == s0_ref) launches++;
      end
      if (res_fire_s && res_S == s0_ref + 32'(NS) * ONE) lasts++;
      if (launches - lasts > max_if) max_if = launches - lasts;
      if (out_valid && out_ready) begin
        n_samples++;
        if (out_S !== s0_ref + 32'(out_step) * ONE) val_err++;
        if (int'(out_step) != last_step[out_path] + 1) order_err++;
        last_step[out_path] = int'(out_step);
        if (!first_seen) begin
          first_seen = 1;
          first_path = int'(out_path);
          first_step = int'(out_step);
          first_s = out_S;
        end
      end
      if (ostall && (!out_valid || {out_S, out_path, out_step} !== opl)) stab_err++;
      if (gstall && (!gbm_valid || gbm_S !== gpl)) gstab_err++;
      if (done) done_cnt++;
    end
    ostall = rst_n && out_valid && !out_ready;
    opl = {out_S, out_path, out_step};
    gstall = rst_n && gbm_valid && !gbm_ready && z_valid;
    gpl = gbm_S;
  end
  // GBM lane model: S_next = S + ONE, in order, result offered 5 edges after issue
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!rst_n) pipe.delete();
    else begin
      if (res_fire_s) void'(pipe.pop_front());
      if (gbm_fire_s) pipe.push_back('{s: gbm_s_s + ONE, due: cyc + 5});
    end
    res_valid = 0;
    res_S = 0;
    if (pipe.size() > 0 && pipe[0].due <= cyc) begin
      res_valid = 1;
      res_S = pipe[0].s;
    end
    out_ready = out_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  function automatic int n_complete();
    int c = 0;
    foreach (last_step[p]) if (last_step[p] == NS) c++;
    return c;
  endfunction
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic clear_stats();
    n_samples = 0; val_err = 0; order_err = 0; stab_err = 0; gstab_err = 0; done_cnt = 0;
    launches = 0; lasts = 0; max_if = 0; first_seen = 0; ostall = 0; gstall = 0;
    foreach (last_step[p]) last_step[p] = 0;
    gbm_log.delete();
  endtask
  task automatic do_start(input logic [31:0] s0v);
    S0 = s0v;
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic wait_done(input string name);
    bit ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      tick();
      ok = done_cnt != 0;
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL %s_timeout: done not seen within 3000 cycles", name); end
  endtask
  task automatic test_reset();
    rst_n = 0; z_valid = 1; z = 0;
    repeat (3) tick();
    n_checks++; if (gbm_valid !== 1'b0) begin n_fail++; $display("FAIL reset_gbm_valid: got %0b exp 0", gbm_valid); end
    n_checks++; if (res_ready !== 1'b0) begin n_fail++; $display("FAIL reset_res_ready: got %0b exp 0", res_ready); end
    rst_n = 1;
    tick();
    n_checks++; if ({z_ready, out_valid, busy, done} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b exp 0000", {z_ready, out_valid, busy, done}); end
    n_checks++; if ({out_S, out_path, out_step} !== 38'h0) begin n_fail++; $display("FAIL reset_out_payload: got %h exp 0", {out_S, out_path, out_step}); end
    n_checks++; if ({gbm_S, gbm_r, gbm_sigma, gbm_dt, gbm_z} !== 160'h0) begin n_fail++; $display("FAIL reset_gbm_payload: got %h exp 0", {gbm_S, gbm_r, gbm_sigma, gbm_dt}); end
  endtask
  task automatic test_basic_run();
    clear_stats();
    r = 32'h0000_0CCD; sigma = 32'h0000_3333; dt = 32'h0000_051F; z = 32'h0000_1234;
    do_start(S100);
    r = 32'hDEAD_0000; sigma = 0; dt = 0;
    tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_run: got %0b exp 1", busy); end
    n_checks++; if ({gbm_r, gbm_sigma, gbm_dt} !== {32'h0000_0CCD, 32'h0000_3333, 32'h0000_051F}) begin n_fail++; $display("FAIL basic_latched_params: got %h %h %h exp 00000ccd 00003333 0000051f", gbm_r, gbm_sigma, gbm_dt); end
    n_checks++; if (gbm_z !== 32'h0000_1234) begin n_fail++; $display("FAIL basic_gbm_z: got %h exp 00001234", gbm_z); end
    wait_done("basic");
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %0b exp 0", busy); end
    n_checks++; if (n_samples != NP * NS) begin n_fail++; $display("FAIL basic_sample_count: got %0d exp %0d", n_samples, NP * NS); end
    n_checks++; if (val_err != 0 || order_err != 0) begin n_fail++; $display("FAIL basic_values: got val_err=%0d order_err=%0d exp 0 0", val_err, order_err); end
    n_checks++; if (n_complete() != NP) begin n_fail++; $display("FAIL basic_complete_paths: got %0d exp %0d", n_complete(), NP); end
    n_checks++; if ({first_path, first_step} != {32'd0, 32'd1} || first_s !== S100 + ONE) begin n_fail++; $display("FAIL basic_first_sample: got path %0d step %0d S %h exp 0 1 %h", first_path, first_step, first_s, S100 + ONE); end
    n_checks++; if (max_if != 4) begin n_fail++; $display("FAIL basic_max_inflight: got %0d exp 4", max_if); end
    tick();
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d exp 1", done_cnt); end
  endtask
  task automatic test_random_ready();
    clear_stats();
    out_rand = 1;
    do_start(S100);
    wait_done("random");
    out_rand = 0;
    n_checks++; if (n_samples != NP * NS || n_complete() != NP) begin n_fail++; $display("FAIL random_count: got %0d samples %0d paths exp %0d %0d", n_samples, n_complete(), NP * NS, NP); end
    n_checks++; if (val_err != 0 || order_err != 0) begin n_fail++; $display("FAIL random_values: got val_err=%0d order_err=%0d exp 0 0", val_err, order_err); end
    n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL random_out_stable: got %0d changes exp 0", stab_err); end
    n_checks++; if (max_if > 4) begin n_fail++; $display("FAIL random_max_inflight: got %0d exp <=4", max_if); end
  endtask
  task automatic test_z_gap();
    int bad = 0, nlog;
    clear_stats();
    do_start(S100);
    repeat (8) tick();
    z_valid = 0;
    nlog = gbm_log.size();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gbm_valid !== 1'b0 || z_ready !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL zgap_valid_low: got %0d active cycles exp 0", bad); end
    n_checks++; if (gbm_log.size() != nlog) begin n_fail++; $display("FAIL zgap_no_issue: got %0d issues exp 0", gbm_log.size() - nlog); end
    z_valid = 1;
    wait_done("zgap");
    n_checks++; if (n_samples != NP * NS || n_complete() != NP) begin n_fail++; $display("FAIL zgap_count: got %0d samples %0d paths exp %0d %0d", n_samples, n_complete(), NP * NS, NP); end
    n_checks++; if (val_err != 0 || order_err != 0) begin n_fail++; $display("FAIL zgap_tags: got val_err=%0d order_err=%0d exp 0 0", val_err, order_err); end
  endtask
  task automatic test_gbm_stall();
    int bad = 0, idx;
    clear_stats();
    do_start(S100);
    for (int i = 0; i < 20 && launches < 3; i++) tick();
    gbm_ready = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (gbm_valid !== 1'b1 || gbm_S !== S100) bad++;
    end
    n_checks++; if (bad != 0 || gstab_err != 0) begin n_fail++; $display("FAIL stall_locked_payload: got %0d bad cycles %0d changes exp 0 0", bad, gstab_err); end
    n_checks++; if ({res_valid, res_ready} !== 2'b10) begin n_fail++; $display("FAIL stall_recirc_waits: got res_valid/res_ready %b exp 10", {res_valid, res_ready}); end
    idx = gbm_log.size();
    gbm_ready = 1;
    tick();
    tick();
    n_checks++;
    if (gbm_log.size() < idx + 2) begin n_fail++; $display("FAIL stall_release_order: got %0d issues exp 2", gbm_log.size() - idx); end
    else if (gbm_log[idx] !== S100 || gbm_log[idx + 1] !== S100 + ONE) begin n_fail++; $display("FAIL stall_release_order: got %h then %h exp %h then %h", gbm_log[idx], gbm_log[idx + 1], S100, S100 + ONE); end
    wait_done("stall");
    n_checks++; if (n_samples != NP * NS || val_err != 0 || order_err != 0) begin n_fail++; $display("FAIL stall_run: got %0d samples val_err=%0d order_err=%0d exp %0d 0 0", n_samples, val_err, order_err, NP * NS); end
  endtask
  task automatic test_busy_start_reset();
    int n200 = 0;
    clear_stats();
    do_start(S100);
    repeat (5) tick();
    S0 = S200;
    start = 1;
    tick();
    start = 0;
    repeat (12) tick();
    foreach (gbm_log[i]) if (gbm_log[i] == S200) n200++;
    n_checks++; if (n200 != 0 || val_err != 0) begin n_fail++; $display("FAIL busy_start_ignored: got %0d S200 issues val_err=%0d exp 0 0", n200, val_err); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_start_still_busy: got %0b exp 1", busy); end
    rst_n = 0;
    #1;
    n_checks++; if ({gbm_valid, z_ready, res_ready, out_valid, busy, done} !== 6'b0) begin n_fail++; $display("FAIL midreset_flags: got %b exp 000000", {gbm_valid, z_ready, res_ready, out_valid, busy, done}); end
    n_checks++; if ({out_S, out_path, out_step, gbm_S, gbm_r} !== 102'h0) begin n_fail++; $display("FAIL midreset_data: got out %h gbm_S %h gbm_r %h exp 0", out_S, gbm_S, gbm_r); end
    tick();
    tick();
    rst_n = 1;
    tick();
    clear_stats();
    do_start(S100);
    wait_done("fresh");
    n_checks++; if (n_samples != NP * NS || n_complete() != NP) begin n_fail++; $display("FAIL fresh_count: got %0d samples %0d paths exp %0d %0d", n_samples, n_complete(), NP * NS, NP); end
    n_checks++; if (val_err != 0 || order_err != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL fresh_run: got val_err=%0d order_err=%0d busy=%0b exp 0 0 0", val_err, order_err, busy); end
  endtask
  initial begin
    test_reset();
    test_basic_run();
    test_random_ready();
    test_z_gap();
    test_gbm_stall();
    test_busy_start_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
